mem_arbiter: RTL and testbench

//  Two-port arbiter sharing one memory_async instance between instruction fetch (port 0) and data access (port 1).

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (port 0)
// and data access (port 1) using the enable/rw/ack handshake.
// Each transaction runs IDLE -> BUSY -> DRAIN. The next grant is held off
// until memory has withdrawn ack and the served port has dropped enable.
// Build options:
//   MEM_ARB_RR_EN  defined: round-robin on simultaneous requests
//                  undefined (default): fixed priority, port 1 over port 0
module mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0: instruction fetch
  input  logic                  p0_enable,
  input  logic                  p0_rw,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0]      p0_data_in,
  output logic [WIDTH-1:0]      p0_data_out,
  output logic                  p0_ack,
  // port 1: data access
  input  logic                  p1_enable,
  input  logic                  p1_rw,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0]      p1_data_in,
  output logic [WIDTH-1:0]      p1_data_out,
  output logic                  p1_ack,
  // shared memory side
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data_in,
  input  logic [WIDTH-1:0]      mem_data_out,
  input  logic                  mem_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;

  logic any_req;
  logic win;
  logic grant_en;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
`endif

  // Pick the port to serve if a grant happens this cycle.
  always_comb begin
    any_req = p0_enable | p1_enable;
`ifdef MEM_ARB_RR_EN
    if (p0_enable && p1_enable) begin
      win = ptr_q;
    end else begin
      win = p1_enable;
    end
`else
    win = p1_enable;
`endif
    grant_en = grant_q ? p1_enable : p0_enable;
  end

  // Next-state logic; the request is captured only at grant so later
  // changes on the served port's inputs have no effect.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          grant_d = win;
          rw_d    = win ? p1_rw      : p0_rw;
          addr_d  = win ? p1_addr    : p0_addr;
          data_d  = win ? p1_data_in : p0_data_in;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!mem_ack && !grant_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and latched request; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Tie-break pointer: after every grant the other port becomes preferred.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req) begin
      ptr_d = ~win;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign mem_enable  = (state_q == ST_BUSY);
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_q;

  // Ack is passed through only to the granted port and only while BUSY.
  assign p0_ack = mem_enable & mem_ack & ~grant_q;
  assign p1_ack = mem_enable & mem_ack &  grant_q;

  assign p0_data_out = mem_data_out;
  assign p1_data_out = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-3 memory responder, directed scenarios
// and a randomized phase, all checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned W       = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned LATENCY = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_enable, p0_rw, p0_ack;
  logic [AW-1:0] p0_addr;
  logic [W-1:0]  p0_data_in, p0_data_out;
  logic          p1_enable, p1_rw, p1_ack;
  logic [AW-1:0] p1_addr;
  logic [W-1:0]  p1_data_in, p1_data_out;
  logic          mem_enable, mem_rw, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data_in, mem_data_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .p0_enable(p0_enable), .p0_rw(p0_rw), .p0_addr(p0_addr),
    .p0_data_in(p0_data_in), .p0_data_out(p0_data_out), .p0_ack(p0_ack),
    .p1_enable(p1_enable), .p1_rw(p1_rw), .p1_addr(p1_addr),
    .p1_data_in(p1_data_in), .p1_data_out(p1_data_out), .p1_ack(p1_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ack(mem_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pattern(input int unsigned i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 + i;
  endfunction

  // ---------------- memory responder (latency LATENCY cycles) -------------
  logic [31:0] mem_store [64];
  int unsigned lat_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ack      <= 1'b0;
      mem_data_out <= '0;
      lat_cnt      <= 0;
      for (int unsigned i = 0; i < 64; i++) mem_store[i] <= pattern(i);
    end else if (!mem_enable) begin
      mem_ack <= 1'b0;
      lat_cnt <= 0;
    end else if (!mem_ack) begin
      if (lat_cnt == LATENCY - 1) begin
        mem_ack <= 1'b1;
        if (mem_rw) mem_store[mem_addr[7:2]] <= mem_data_in;
        else        mem_data_out <= mem_store[mem_addr[7:2]];
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // ---------------- transaction-level reference model ---------------------
  logic [31:0] ref_mem [64];
  logic        prev_men;
  logic [1:0]  prev_en;
  logic        prev_rw [2];
  logic [31:0] prev_a [2];
  logic [31:0] prev_d [2];
  logic        svc_v, svc_p, svc_rw, ptr_m, exp_p;
  logic [31:0] svc_a, svc_d;
  int unsigned svc_age;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_men = 1'b0;
        prev_en  = 2'b00;
        svc_v    = 1'b0;
        svc_p    = 1'b0;
        ptr_m    = 1'b0;
        svc_age  = 0;
        for (int unsigned i = 0; i < 64; i++) ref_mem[i] = pattern(i);
      end else begin
        // a new transaction appears on the memory side
        if (mem_enable && !prev_men) begin
          check_eq("grant_has_req", prev_en != 2'b00, 1'b1);
          check_eq("grant_after_done", svc_v, 1'b0);
          if (prev_en == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            exp_p = ptr_m;
`else
            exp_p = 1'b1;
`endif
          end else begin
            exp_p = prev_en[1];
          end
          ptr_m   = ~exp_p;
          svc_v   = 1'b1;
          svc_p   = exp_p;
          svc_rw  = prev_rw[exp_p];
          svc_a   = prev_a[exp_p];
          svc_d   = prev_d[exp_p];
          svc_age = 0;
          if (svc_rw) check_eq("grant_wdata", mem_data_in, svc_d);
        end
        // latched request must stay put for the whole transfer
        if (mem_enable && svc_v) begin
          check_eq("hold_addr", mem_addr, svc_a);
          check_eq("hold_rw", mem_rw, svc_rw);
        end
        if (p0_ack || p1_ack) begin
          check_eq("ack_overlap", p0_ack & p1_ack, 1'b0);
          check_eq("ack_valid", svc_v, 1'b1);
          check_eq("ack_port", p1_ack, svc_p);
          if (svc_rw) begin
            ref_mem[svc_a[7:2]] = svc_d;
          end else begin
            check_eq("rdata_p0", p0_data_out, ref_mem[svc_a[7:2]]);
            check_eq("rdata_p1", p1_data_out, ref_mem[svc_a[7:2]]);
          end
          svc_v = 1'b0;
        end
        if (svc_v) begin
          svc_age++;
          if (svc_age > 40) begin
            check_eq("svc_timeout", svc_age, 40);
            svc_v = 1'b0;
          end
        end
        prev_men   = mem_enable;
        prev_en    = {p1_enable, p0_enable};
        prev_rw[0] = p0_rw;  prev_rw[1] = p1_rw;
        prev_a[0]  = p0_addr; prev_a[1] = p1_addr;
        prev_d[0]  = p0_data_in; prev_d[1] = p1_data_in;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  bit          act [2];
  int unsigned cool [2];
  int          order [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic en, input logic rw,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_enable = en; p0_rw = rw; p0_addr = a; p0_data_in = d;
    end else begin
      p1_enable = en; p1_rw = rw; p1_addr = a; p1_data_in = d;
    end
  endtask

  task automatic set_en(input int p, input logic en);
    if (p == 0) p0_enable = en;
    else        p1_enable = en;
  endtask

  task automatic wait_ack(input int p, output bit ok, output logic [31:0] d, output bit other);
    ok = 1'b0; other = 1'b0; d = '0;
    for (int unsigned t = 0; t < 40; t++) begin
      tick();
      if ((p == 0 ? p1_ack : p0_ack) == 1'b1) other = 1'b1;
      if ((p == 0 ? p0_ack : p1_ack) == 1'b1) begin
        ok = 1'b1;
        d  = (p == 0) ? p0_data_out : p1_data_out;
        break;
      end
    end
  endtask

  task automatic wait_men(output bit ok);
    ok = 1'b0;
    for (int unsigned t = 0; t < 40; t++) begin
      if (mem_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // mode 0: random requests with input scrambling/early drop while served
  // mode 1: both ports re-request as soon as allowed, reads only
  task automatic run_ports(input int mode, input int unsigned max_ticks, input int unsigned target);
    logic [31:0] a;
    logic        ack;
    for (int unsigned t = 0; t < max_ticks; t++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        ack = (p == 0) ? p0_ack : p1_ack;
        if (act[p]) begin
          if (ack) begin
            order.push_back(p);
            act[p]  = 1'b0;
            cool[p] = 2;
            set_en(p, 1'b0);
          end else if (mode == 0 && svc_v && (int'(svc_p) == p) && $urandom_range(0, 3) == 0) begin
            drive(p, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom);
          end
        end else if (cool[p] != 0) begin
          cool[p]--;
        end else if (order.size() < target && (mode == 1 || $urandom_range(0, 5) == 0)) begin
          a = {24'd0, p[0], 5'($urandom_range(0, 31)), 2'b00};
          act[p] = 1'b1;
          drive(p, 1'b1, (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0, a, $urandom);
        end
      end
      if (order.size() >= target && !act[0] && !act[1]) break;
    end
    check_eq("run_complete", (order.size() >= target) && !act[0] && !act[1], 1'b1);
  endtask

  // ---------------- main sequence ------------------------------------------
  bit          ok, other;
  logic [31:0] rd;
  int unsigned lows;
  int          first;
  int          exp_seq [3];

  initial begin
    act[0] = 1'b0; act[1] = 1'b0; cool[0] = 0; cool[1] = 0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #12;
    check_eq("rst_mem_enable", mem_enable, 1'b0);
    check_eq("rst_mem_rw", mem_rw, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_data_in", mem_data_in, 0);
    check_eq("rst_p0_ack", p0_ack, 1'b0);
    check_eq("rst_p1_ack", p1_ack, 1'b0);
    #5 reset = 1'b0;

    // single read on port 0
    tick();
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    wait_ack(0, ok, rd, other);
    check_eq("t1_ack", ok, 1'b1);
    check_eq("t1_data", rd, 32'hDEAD_BEEF);
    check_eq("t1_p1_ack_quiet", other, 1'b0);
    set_en(0, 1'b0);
    repeat (3) tick();

    // write then read back on port 1, memory enable must drop in between
    drive(1, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    wait_ack(1, ok, rd, other);
    check_eq("t2_wr_ack", ok, 1'b1);
    set_en(1, 1'b0);
    lows = 0;
    for (int unsigned t = 0; t < 40; t++) begin
      tick();
      if (t == 3) drive(1, 1'b1, 1'b0, 32'h40, '0);
      if (mem_enable) break;
      lows++;
    end
    check_eq("t2_gap", lows >= 1, 1'b1);
    wait_ack(1, ok, rd, other);
    check_eq("t2_rd_ack", ok, 1'b1);
    check_eq("t2_rd_data", rd, 32'h1234_5678);
    set_en(1, 1'b0);
    repeat (3) tick();

    // simultaneous requests
    drive(0, 1'b1, 1'b0, 32'h08, '0);
    drive(1, 1'b1, 1'b0, 32'h88, '0);
    first = -1;
    for (int unsigned t = 0; t < 40; t++) begin
      tick();
      if (p0_ack || p1_ack) begin
        first = p1_ack ? 1 : 0;
        break;
      end
    end
`ifdef MEM_ARB_RR_EN
    check_eq("t3_first", first, 0);
`else
    check_eq("t3_first", first, 1);
`endif
    set_en(first == 0 ? 0 : 1, 1'b0);
    wait_ack(first == 0 ? 1 : 0, ok, rd, other);
    check_eq("t3_second_ack", ok, 1'b1);
    set_en(0, 1'b0);
    set_en(1, 1'b0);
    repeat (3) tick();

    // port 0 drops enable while BUSY; port 1 queued behind it
    drive(0, 1'b1, 1'b0, 32'h20, '0);
    tick();
    wait_men(ok);
    check_eq("t6_grant", ok, 1'b1);
    drive(1, 1'b1, 1'b0, 32'h84, '0);
    tick();
    set_en(0, 1'b0);
    wait_ack(0, ok, rd, other);
    check_eq("t6_early_ack", ok, 1'b1);
    check_eq("t6_early_data", rd, pattern(8));
    wait_ack(1, ok, rd, other);
    check_eq("t6_p1_ack", ok, 1'b1);
    check_eq("t6_p1_data", rd, pattern(33));
    set_en(1, 1'b0);
    repeat (3) tick();

    // randomized traffic
    order.delete();
    run_ports(0, 4000, 150);
    repeat (3) tick();

    // reset two cycles into a transfer
    drive(0, 1'b1, 1'b0, 32'h30, '0);
    tick();
    wait_men(ok);
    check_eq("t5_grant", ok, 1'b1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("t5_mem_enable", mem_enable, 1'b0);
    check_eq("t5_p0_ack", p0_ack, 1'b0);
    check_eq("t5_p1_ack", p1_ack, 1'b0);
    check_eq("t5_mem_addr", mem_addr, 0);
    set_en(0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    tick();
    check_eq("t5_idle_after", mem_enable, 1'b0);

    // back-to-back contention rounds straight after reset
    order.delete();
    act[0] = 1'b0; act[1] = 1'b0; cool[0] = 0; cool[1] = 0;
    run_ports(1, 300, 3);
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{1, 1, 1};
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("t4_grant_order", (order.size() > i) ? order[i] : -1, exp_seq[i]);
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
